// File: rtl/mux_scan_sel.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_sel
// Purpose  : Registered CHANNELS-to-1 selector, manual or round-robin scan.
// Revision : 1.0  initial release
// ============================================================================
module mux_scan_sel #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int DWELL    = 4,
   parameter int SELW     = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [CHANNELS*WIDTH-1:0] data_in,
   input  logic [SELW-1:0]           sel,
   input  logic                      mode,
   input  logic [CHANNELS-1:0]       enable,
   input  logic                      hold,
   output logic [WIDTH-1:0]          data_out,
   output logic [SELW-1:0]           chan_out,
   output logic                      switched
);

   localparam int              C_CW   = $clog2(DWELL) + 1;
   localparam logic [C_CW-1:0] C_LAST = C_CW'(DWELL - 1);
   localparam logic [SELW:0]   C_NCH  = (SELW + 1)'(CHANNELS);

   typedef enum logic [0:0] {
      ST_MANUAL = 1'b0,
      ST_SCAN   = 1'b1
   } state_t;

   state_t            r_state;
   logic [C_CW-1:0]   r_cnt;

   logic [WIDTH-1:0]  w_lane [CHANNELS];
   logic              w_sel_ok;
   logic              w_adv;
   logic              w_found;
   logic [SELW:0]     w_idx;
   logic [SELW-1:0]   w_next_en;
   logic [SELW-1:0]   w_chan_next;

   for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
      assign w_lane[k] = data_in[k*WIDTH +: WIDTH];
   end

   assign w_sel_ok = ({1'b0, sel} < C_NCH);
   assign w_adv    = (r_state == ST_SCAN) && mode && (|enable) && !hold
                     && (r_cnt == C_LAST);

   // First enabled channel after chan_out, wrapping; falls back to chan_out.
   always_comb begin
      w_next_en = chan_out;
      w_found   = 1'b0;
      w_idx     = '0;
      for (int i = 1; i <= CHANNELS; i++) begin
         w_idx = {1'b0, chan_out} + (SELW + 1)'(i);
         if (w_idx >= C_NCH) begin
            w_idx = w_idx - C_NCH;
         end
         if (!w_found && enable[w_idx[SELW-1:0]]) begin
            w_found   = 1'b1;
            w_next_en = w_idx[SELW-1:0];
         end
      end
   end

   // mode=0 covers both MANUAL and the SCAN->MANUAL edge; the MANUAL->SCAN edge keeps chan_out.
   always_comb begin
      w_chan_next = chan_out;
      if (!mode) begin
         if (w_sel_ok) begin
            w_chan_next = sel;
         end
      end else if (w_adv) begin
         w_chan_next = w_next_en;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= ST_MANUAL;
         r_cnt    <= '0;
         data_out <= '0;
         chan_out <= '0;
         switched <= 1'b0;
      end else begin
         chan_out <= w_chan_next;
         data_out <= w_lane[w_chan_next];
         switched <= (w_chan_next != chan_out);
         case (r_state)
            ST_MANUAL: begin
               if (mode) begin
                  r_state <= ST_SCAN;
                  r_cnt   <= '0;
               end
            end
            ST_SCAN: begin
               if (!mode) begin
                  r_state <= ST_MANUAL;
                  r_cnt   <= '0;
               end else if (enable == '0) begin
                  r_cnt <= '0;
               end else if (!hold) begin
                  r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= ST_MANUAL;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
